sd_cmd_resp_rx: RTL



---
 rtl/sd_pkg.sv | 19 +
 rtl/sd_cmd_resp_rx_if.sv | 31 +++
 rtl/sd_crc7.sv | 24 ++
 rtl/sd_cmd_resp_rx.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants and types for the SD CMD-line blocks
//
// Frame lengths, CRC7 polynomial, receiver state encoding and the default
// start-bit timeout (NCR window, in sample strobes).
package sd_pkg;

    localparam int R48_LEN          = 48;
    localparam int R136_LEN         = 136;
    localparam logic [6:0] CRC7_POLY = 7'h09;    // x^7 + x^3 + 1, x^7 implied
    localparam int TIMEOUT_CLKS_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        SHIFT,
        DONE
    } rx_state_t;

endpackage

// File: rtl/sd_cmd_resp_rx_if.sv
// rtl/sd_cmd_resp_rx_if.sv - sequencer-to-response-receiver signal bundle
//
// master : sequencer / pad side (drives strobe, cmd_in, arm and frame options)
// slave  : sd_cmd_resp_rx (drives busy, pulses, captured frame and flags)
interface sd_cmd_resp_rx_if;
    import sd_pkg::*;

    logic                sample_stb;
    logic                cmd_in;
    logic                arm;
    logic                long_resp;
    logic                crc_chk;
    logic                busy;
    logic                resp_valid;
    logic                timeout;
    logic [R136_LEN-1:0] resp_data;
    logic [5:0]          resp_index;
    logic                crc_err;
    logic                frame_err;

    modport master (
        output sample_stb, cmd_in, arm, long_resp, crc_chk,
        input  busy, resp_valid, timeout, resp_data, resp_index, crc_err, frame_err
    );

    modport slave (
        input  sample_stb, cmd_in, arm, long_resp, crc_chk,
        output busy, resp_valid, timeout, resp_data, resp_index, crc_err, frame_err
    );

endinterface

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 (x^7+x^3+1), seed 0
//
// Ports: clk, rst (sync, active-high); clear zeroes the remainder;
// en advances one bit with din; crc is the running remainder.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ ({7{din ^ crc[6]}} & CRC7_POLY);
        end
    end

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// rtl/sd_cmd_resp_rx.sv - SD CMD-line response receiver (48/136-bit frames)
//
// Ports: clk, rst (sync, active-high); bus (sd_cmd_resp_rx_if.slave):
//   sample_stb/cmd_in  CMD line sampled on SD-clock strobes
//   arm/long_resp/crc_chk  start a receive, options latched at arm
//   busy, resp_valid, timeout, resp_data, resp_index, crc_err, frame_err
// Optional: SD_RESP_CRC_EN builds the CRC7 checker; otherwise crc_err is 0.
module sd_cmd_resp_rx
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF,
    parameter int CNT_W        = 8
)
(
    input  logic clk,
    input  logic rst,
    sd_cmd_resp_rx_if.slave bus
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    rx_state_t        state, state_d;
    logic             long_q;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] last_idx;

    logic start_arm, start_bit, shift_bit, hunt_miss, fire_to, last_bit;

    assign last_idx = long_q ? CNT_W'(R136_LEN - 1) : CNT_W'(R48_LEN - 1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        start_arm = 1'b0;
        start_bit = 1'b0;
        shift_bit = 1'b0;
        hunt_miss = 1'b0;
        fire_to   = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.arm) begin
                    start_arm = 1'b1;
                    state_d   = HUNT;
                end
            end
            HUNT: begin
                if (bus.sample_stb) begin
                    if (!bus.cmd_in) begin
                        start_bit = 1'b1;
                        state_d   = SHIFT;
                    end else begin
                        hunt_miss = 1'b1;
                        if (to_cnt == TO_LAST) begin
                            fire_to = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            SHIFT: begin
                if (bus.sample_stb) begin
                    shift_bit = 1'b1;
                    if (bit_cnt == last_idx) begin
                        last_bit = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SD_RESP_CRC_EN
    logic       chk_q;
    logic       crc_en;
    logic [6:0] crc;

    // Start bit is covered only for 48-bit frames; R2 CRC starts at bit 127.
    // The incoming bit index is last_idx - bit_cnt; stop before bit 7.
    assign crc_en = (start_bit && !long_q) ||
                    (shift_bit && (long_q ? (bit_cnt >= CNT_W'(8) && bit_cnt <= CNT_W'(127))
                                          : (bit_cnt <= CNT_W'(39))));

    sd_crc7 u_crc7 (
        .clk   (clk),
        .rst   (rst),
        .clear (start_arm),
        .en    (crc_en),
        .din   (bus.cmd_in),
        .crc   (crc)
    );

    always_ff @(posedge clk) begin
        if (rst)            chk_q <= 1'b0;
        else if (start_arm) chk_q <= bus.crc_chk;
    end
`endif

    // Flags are resolved on the end-bit strobe itself (using the pre-shift
    // register plus cmd_in), so resp_valid can be the DONE-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_q         <= 1'b0;
            bit_cnt        <= '0;
            to_cnt         <= '0;
            bus.busy       <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_index <= '0;
            bus.crc_err    <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.resp_valid <= last_bit;
            bus.timeout    <= fire_to;
            if (start_arm) begin
                long_q         <= bus.long_resp;
                bit_cnt        <= '0;
                to_cnt         <= '0;
                bus.busy       <= 1'b1;
                bus.resp_data  <= '0;
                bus.resp_index <= '0;
                bus.crc_err    <= 1'b0;
                bus.frame_err  <= 1'b0;
            end
            if (hunt_miss) to_cnt <= to_cnt + 1'b1;
            if (start_bit) bit_cnt <= CNT_W'(1);
            if (shift_bit) bit_cnt <= bit_cnt + 1'b1;
            if (start_bit || shift_bit)
                bus.resp_data <= {bus.resp_data[R136_LEN-2:0], bus.cmd_in};
            if (last_bit) begin
                bus.busy       <= 1'b0;
                bus.resp_index <= long_q ? bus.resp_data[132:127] : bus.resp_data[44:39];
                bus.frame_err  <= (long_q ? bus.resp_data[133] : bus.resp_data[45]) | ~bus.cmd_in;
`ifdef SD_RESP_CRC_EN
                bus.crc_err    <= chk_q & (crc != bus.resp_data[6:0]);
`else
                bus.crc_err    <= 1'b0;
`endif
            end
            if (fire_to) bus.busy <= 1'b0;
        end
    end

endmodule
